// File: rtl/imem_boot_loader.sv
// imem_boot_loader: receives a little-endian byte stream after reset, packs
// it into 32-bit instruction words, writes them to consecutive imem word
// addresses and then releases the core from reset. A zero word ends the
// program, and so does a full memory. A stalled partial word ends in a
// sticky error.
module imem_boot_loader #(
  parameter int ADDR_WIDTH     = 10,
  parameter int MAX_WORDS      = 1024,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_reset,
  output logic                  load_done,
  output logic                  load_error,
  output logic [ADDR_WIDTH:0]   word_count
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] MAX_CNT     = CW'(MAX_WORDS);
  localparam logic [31:0]   TIMEOUT_VAL = 32'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    RECV  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2,
    ERROR = 2'd3
  } state_t;

  state_t          state_reg, state_next;
  logic [1:0]      byte_idx_reg, byte_idx_next;
  logic [31:0]     idle_reg, idle_next;
  logic [31:0]     word_reg, word_next;
  logic [CW-1:0]   count_reg, count_next;

  logic                  in_ready_reg;
  logic                  imem_we_reg;
  logic [ADDR_WIDTH-1:0] imem_addr_reg;
  logic [31:0]           imem_wdata_reg;
  logic                  cpu_reset_reg;
  logic                  load_done_reg;
  logic                  load_error_reg;

  // A byte is taken only while receiving and while in_ready is shown high.
  logic accept;
  assign accept = (state_reg == RECV) && in_ready_reg && in_valid;

  // Next-state logic: byte packing, idle timeout and end-of-load decision.
  always_comb begin
    state_next    = state_reg;
    byte_idx_next = byte_idx_reg;
    idle_next     = idle_reg;
    word_next     = word_reg;
    count_next    = count_reg;
    case (state_reg)
      RECV: begin
        if (accept) begin
          idle_next     = 32'd0;
          byte_idx_next = byte_idx_reg + 2'd1;
          case (byte_idx_reg)
            2'd0:    word_next[7:0]   = in_data;
            2'd1:    word_next[15:8]  = in_data;
            2'd2:    word_next[23:16] = in_data;
            default: word_next[31:24] = in_data;
          endcase
          if (byte_idx_reg == 2'd3) begin
            state_next = WRITE;
          end
        end else if (byte_idx_reg != 2'd0) begin
          // Only a partially received word can time out; gaps between
          // complete words are unlimited.
          if ((idle_reg + 32'd1) >= TIMEOUT_VAL) begin
            state_next = ERROR;
            idle_next  = 32'd0;
          end else begin
            idle_next = idle_reg + 32'd1;
          end
        end
      end
      WRITE: begin
        count_next = count_reg + 1'b1;
        if (word_reg == 32'd0) begin
          state_next = DONE;
        end else if ((count_reg + 1'b1) == MAX_CNT) begin
          state_next = DONE;
        end else begin
          state_next = RECV;
        end
      end
      DONE:    state_next = DONE;
      default: state_next = ERROR;
    endcase
  end

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= RECV;
      byte_idx_reg <= 2'd0;
      idle_reg     <= 32'd0;
      word_reg     <= 32'd0;
      count_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      byte_idx_reg <= byte_idx_next;
      idle_reg     <= idle_next;
      word_reg     <= word_next;
      count_reg    <= count_next;
    end
  end

  // Registered outputs: the write strobe is launched on the edge that takes
  // byte 3 so the complete word is presented during the WRITE cycle; status
  // flags follow the state one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready_reg   <= 1'b0;
      imem_we_reg    <= 1'b0;
      imem_addr_reg  <= '0;
      imem_wdata_reg <= 32'd0;
      cpu_reset_reg  <= 1'b1;
      load_done_reg  <= 1'b0;
      load_error_reg <= 1'b0;
    end else begin
      in_ready_reg  <= (state_next == RECV);
      imem_we_reg   <= (state_reg == RECV) && (state_next == WRITE);
      if ((state_reg == RECV) && (state_next == WRITE)) begin
        imem_addr_reg  <= count_reg[ADDR_WIDTH-1:0];
        imem_wdata_reg <= word_next;
      end
      cpu_reset_reg  <= (state_reg != DONE);
      load_done_reg  <= (state_reg == DONE);
      load_error_reg <= (state_reg == ERROR);
    end
  end

  assign in_ready   = in_ready_reg;
  assign imem_we    = imem_we_reg;
  assign imem_addr  = imem_addr_reg;
  assign imem_wdata = imem_wdata_reg;
  assign cpu_reset  = cpu_reset_reg;
  assign load_done  = load_done_reg;
  assign load_error = load_error_reg;
  assign word_count = count_reg;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: scoreboard of expected imem writes plus a
// vector table for the basic three-word program and hand sequences for
// capacity, timeout, mid-load reset and long inter-word gaps.
module tb_imem_boot_loader;
  localparam int AW   = 10;
  localparam int MAXW = 4;
  localparam int TMO  = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'd0;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_reset;
  logic          load_done;
  logic          load_error;
  logic [AW:0]   word_count;

  imem_boot_loader #(
    .ADDR_WIDTH(AW),
    .MAX_WORDS(MAXW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .imem_we(imem_we),
    .imem_addr(imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset),
    .load_done(load_done),
    .load_error(load_error),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t           exp_q[$];
  int            exp_count;
  bit            exp_done;
  int            write_seen;
  logic [7:0]    cur_bytes[4];
  int            nb;
  logic [AW-1:0] last_addr;
  logic [31:0]   last_data;

  typedef struct {
    logic [7:0]    b0, b1, b2, b3;
    logic [31:0]   exp_word;
    logic [AW-1:0] exp_addr;
  } vec_t;
  vec_t vecs[3];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end else begin
      $display("ok   %s value=%0h", name, act);
    end
  endtask

  // Scoreboard side: every write strobe must match the oldest expected write.
  always @(negedge clk) begin : monitor
    wr_t e;
    if (!reset && imem_we) begin
      write_seen++;
      last_addr = imem_addr;
      last_data = imem_wdata;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write actual=addr %0d data %h required=no write", imem_addr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr", 64'(imem_addr), 64'(e.addr));
        chk("write_data", 64'(imem_wdata), 64'(e.data));
        chk("ready_low_in_write", 64'(in_ready), 64'd0);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_cpu_reset", 64'(cpu_reset), 64'd1);
    chk("rst_done_err_we", 64'({load_done, load_error, imem_we}), 64'd0);
    chk("rst_word_count", 64'(word_count), 64'd0);
    chk("rst_addr_data", 64'({imem_addr, imem_wdata}), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
    exp_count  = 0;
    exp_done   = 0;
    nb         = 0;
    write_seen = 0;
  endtask

  // Present one byte until accepted or a 20-cycle bound expires; accepted
  // bytes update the reference model of expected writes.
  task automatic send_byte(input logic [7:0] b, output bit acc);
    logic [31:0] w;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    acc      = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) begin
        @(posedge clk);
        acc = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (acc) begin
      cur_bytes[nb] = b;
      nb++;
      if (nb == 4) begin
        nb = 0;
        w = {cur_bytes[3], cur_bytes[2], cur_bytes[1], cur_bytes[0]};
        if (!exp_done) begin
          exp_q.push_back({exp_count[AW-1:0], w});
          exp_count++;
          if (w == 32'd0 || exp_count == MAXW) exp_done = 1;
        end
      end
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic send_expect(input logic [7:0] b);
    bit acc;
    send_byte(b, acc);
    chk("byte_accepted", 64'(acc), 64'd1);
  endtask

  task automatic send_word(input logic [7:0] b0, b1, b2, b3, input int max_gap);
    send_expect(b0);
    if (max_gap > 0) repeat ($urandom_range(max_gap, 1)) @(negedge clk);
    send_expect(b1);
    if (max_gap > 0) repeat ($urandom_range(max_gap, 1)) @(negedge clk);
    send_expect(b2);
    if (max_gap > 0) repeat ($urandom_range(max_gap, 1)) @(negedge clk);
    send_expect(b3);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit acc;
    vecs[0] = '{b0: 8'h93, b1: 8'h00, b2: 8'hA0, b3: 8'h00, exp_word: 32'h00A00093, exp_addr: 10'd0};
    vecs[1] = '{b0: 8'h13, b1: 8'h01, b2: 8'h00, b3: 8'h00, exp_word: 32'h00000113, exp_addr: 10'd1};
    vecs[2] = '{b0: 8'h00, b1: 8'h00, b2: 8'h00, b3: 8'h00, exp_word: 32'h00000000, exp_addr: 10'd2};

    // Basic program, back-to-back, with exact latency of the terminator.
    do_reset();
    @(negedge clk);
    chk("t1_ready_first_cycle", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("t1_ready_rises", 64'(in_ready), 64'd1);
    for (int v = 0; v < 3; v++) begin
      send_word(vecs[v].b0, vecs[v].b1, vecs[v].b2, vecs[v].b3, 0);
      @(negedge clk);
      chk("t1_we_after_byte3", 64'(imem_we), 64'd1);
      @(negedge clk);
      chk("t1_table_addr", 64'(last_addr), 64'(vecs[v].exp_addr));
      chk("t1_table_data", 64'(last_data), 64'(vecs[v].exp_word));
      if (v == 2) begin
        chk("t1_done_not_yet", 64'({load_done, cpu_reset}), 64'b01);
        @(negedge clk);
        chk("t1_done", 64'(load_done), 64'd1);
        chk("t1_cpu_released", 64'(cpu_reset), 64'd0);
        chk("t1_word_count", 64'(word_count), 64'd3);
      end
    end
    chk("t1_queue_empty", 64'(exp_q.size()), 64'd0);

    // Same program with random gaps between bytes.
    do_reset();
    for (int v = 0; v < 3; v++) begin
      send_word(vecs[v].b0, vecs[v].b1, vecs[v].b2, vecs[v].b3, 3);
      repeat ($urandom_range(3, 1)) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    chk("t2_done", 64'(load_done), 64'd1);
    chk("t2_word_count", 64'(word_count), 64'd3);
    chk("t2_writes", 64'(write_seen), 64'd3);
    chk("t2_queue_empty", 64'(exp_q.size()), 64'd0);

    // Capacity: five nonzero words, only four fit.
    do_reset();
    for (int w = 1; w <= 4; w++) begin
      send_word(8'(w), 8'(w + 16), 8'(w + 32), 8'(w + 48), 0);
    end
    send_byte(8'h55, acc);
    chk("t3_fifth_word_refused", 64'(acc), 64'd0);
    chk("t3_done", 64'(load_done), 64'd1);
    chk("t3_word_count", 64'(word_count), 64'd4);
    chk("t3_writes", 64'(write_seen), 64'd4);
    chk("t3_queue_empty", 64'(exp_q.size()), 64'd0);

    // Timeout in the middle of a word.
    do_reset();
    send_expect(8'h93);
    send_expect(8'h00);
    repeat (14) @(negedge clk);
    chk("t4_no_error_early", 64'(load_error), 64'd0);
    repeat (6) @(negedge clk);
    chk("t4_error", 64'(load_error), 64'd1);
    chk("t4_cpu_held", 64'(cpu_reset), 64'd1);
    send_byte(8'hA0, acc);
    chk("t4_byte_ignored", 64'(acc), 64'd0);
    chk("t4_no_writes", 64'(write_seen), 64'd0);
    chk("t4_not_done", 64'(load_done), 64'd0);

    // Reset in the middle of the second word discards the partial word.
    do_reset();
    send_word(8'h11, 8'h22, 8'h33, 8'h44, 0);
    repeat (3) @(negedge clk);
    chk("t5_first_written", 64'(exp_q.size()), 64'd0);
    send_expect(8'hAA);
    send_expect(8'hBB);
    do_reset();
    send_word(8'h37, 8'h00, 8'h00, 8'h00, 0);
    send_word(8'h00, 8'h00, 8'h00, 8'h00, 0);
    repeat (4) @(negedge clk);
    chk("t5_last_addr", 64'(last_addr), 64'd1);
    chk("t5_last_data", 64'(last_data), 64'd0);
    chk("t5_word_count", 64'(word_count), 64'd2);
    chk("t5_done", 64'(load_done), 64'd1);
    chk("t5_writes", 64'(write_seen), 64'd2);

    // Long gap between complete words is legal.
    do_reset();
    send_word(8'h13, 8'h01, 8'h00, 8'h00, 0);
    repeat (100) @(negedge clk);
    chk("t6_no_error_in_gap", 64'(load_error), 64'd0);
    send_word(8'h00, 8'h00, 8'h00, 8'h00, 0);
    repeat (4) @(negedge clk);
    chk("t6_no_error", 64'(load_error), 64'd0);
    chk("t6_done", 64'(load_done), 64'd1);
    chk("t6_word_count", 64'(word_count), 64'd2);
    chk("t6_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Upstream of cpu_pipelined: fills instruction memory from a byte stream after reset, then releases the core.
- Holds the core in reset while loading. Assembles little-endian bytes into 32-bit instruction words and writes them to consecutive imem word addresses.
- Terminates on the all-zero end-of-program word or on reaching capacity. This replaces bench-side direct preloading of imem.

Parameters:
- ADDR_WIDTH, 10, imem word-address width.
- MAX_WORDS, 1024, capacity in words; must be <= 2**ADDR_WIDTH and >= 1.
- TIMEOUT_CYCLES, 65535, idle cycles allowed mid-word before error.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  byte-stream valid.
- in_data  input  8  byte-stream data.
- in_ready  output  1  loader can accept a byte.
- imem_we  output  1  one-cycle instruction-memory write strobe.
- imem_addr  output  ADDR_WIDTH  word address for the write.
- imem_wdata  output  32  instruction word to write.
- cpu_reset  output  1  reset to cpu_pipelined; high until load completes.
- load_done  output  1  load finished; sticky until reset.
- load_error  output  1  stream timed out mid-word; sticky until reset.
- word_count  output  ADDR_WIDTH+1  number of words written, including the terminator.

Behaviour:
- All outputs are registered.
- Reset values: in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset=1, load_done=0, load_error=0, word_count=0. Internally: byte_idx=0, idle counter=0, state RECV. in_ready rises the first cycle after reset deasserts.
- States:
  - RECV: in_ready=1. A byte is accepted on a clk edge where in_valid && in_ready.
    - Byte k (k=0..3) goes to word bits [8k+7:8k] (little-endian); byte_idx increments.
    - On acceptance of byte 3: go to WRITE, byte_idx wraps to 0.
  - WRITE: lasts exactly 1 cycle.
    - imem_we=1, imem_addr=word_count[ADDR_WIDTH-1:0], imem_wdata=assembled word, in_ready=0.
    - Next state:
      - DONE if the word == 32'h00000000 (end-of-program marker; it is still written);
      - else DONE if word_count+1 == MAX_WORDS;
      - else RECV.
    - word_count increments by 1 in every WRITE case, so it always counts words written.
  - DONE: load_done=1, cpu_reset=0, in_ready=0; all input bytes are ignored. Terminal until reset.
  - ERROR: load_error=1, cpu_reset=1, in_ready=0, no writes. Terminal until reset.
- Latency:
  - Byte 3 accepted at edge N -> imem_we high during cycle N..N+1.
  - load_done=1 and cpu_reset=0 from edge N+2 when that word terminates the load.
- Timeout:
  - Applies only in RECV with byte_idx != 0. The idle counter increments each cycle with no accepted byte and clears on each accept.
  - When it reaches TIMEOUT_CYCLES -> ERROR, and the partial word is discarded.
  - No timeout when byte_idx == 0: any gap between words is legal.
- Flow control:
  - in_valid may toggle arbitrarily.
  - A byte presented while in_ready=0 is not consumed; the source must hold it.
- Reset mid-operation: a partial word is discarded with no write, word_count returns to 0, cpu_reset is re-asserted, and loading restarts at address 0.
- Simultaneous events: reset has priority over everything. A byte accepted on the same edge the timeout count would be reached counts as accepted (no error).
- imem is written only through imem_we; no reads are performed by this block.

Test Plan:
1. Bytes 93 00 A0 00, 13 01 00 00, 00 00 00 00 back-to-back -> writes addr0=0x00A00093, addr1=0x00000113, addr2=0x00000000. Then word_count=3, load_done=1, cpu_reset=0 two cycles after the last byte is accepted.
2. Same stream with in_valid deasserted for 1-3 random cycles between bytes -> identical writes. in_ready=0 during each WRITE cycle; no byte dropped or duplicated.
3. MAX_WORDS=4, stream of five nonzero words -> exactly 4 writes (addr 0-3), load_done=1, word_count=4. The fifth word's bytes see in_ready=0 and no further imem_we.
4. TIMEOUT_CYCLES=16, send bytes 93 00 then stop -> load_error=1 after 16 idle cycles, no imem_we, cpu_reset stays 1, subsequent bytes ignored.
5. Assert reset after 2 bytes of the second word, then send 37 00 00 00 00 00 00 00 -> no write of the partial word. addr0=0x00000037, addr1=0x00000000, word_count=2, load_done=1.
6. TIMEOUT_CYCLES=16, 100-cycle gap between complete words -> no load_error; load completes normally.
